// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one LSU load/store at a time, holds it for LATENCY cycles,
// then commits the store or returns the load word with a one-cycle data_valid strobe.
module dmem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_req,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic                       inst_we,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       o_dbg_busy
);

  // Handshake: data_req is held high until the data_valid cycle; data_valid is a
  // single-cycle strobe, and a data_req still high in that cycle is a new request.

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_we;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [BYTE_DATA_WIDTH-1:0] r_be;
  logic                       r_valid;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];

  logic [IDX_W-1:0]           w_idx_in;
  logic                       w_accept;
  logic                       w_do_access;
  logic [IDX_W-1:0]           w_acc_idx;
  logic                       w_acc_we;
  logic [DATA_WIDTH-1:0]      w_acc_wdata;
  logic [BYTE_DATA_WIDTH-1:0] w_acc_be;
  logic                       w_unused_addr;

  assign w_idx_in      = data_addr[IDX_W+1:2];
  assign w_unused_addr = ^{data_addr[DATA_WIDTH-1:IDX_W+2], data_addr[1:0]};
  assign w_accept      = (r_state == S_IDLE) && data_req;

  // With LATENCY=1 the access is done straight from the inputs at the acceptance edge.
  assign w_do_access = (w_accept && (LATENCY == 1)) ||
                       ((r_state == S_BUSY) && (r_cnt == CNT_W'(1)));
  assign w_acc_idx   = (r_state == S_IDLE) ? w_idx_in    : r_idx;
  assign w_acc_we    = (r_state == S_IDLE) ? inst_we     : r_we;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata       : r_wdata;
  assign w_acc_be    = (r_state == S_IDLE) ? byte_enable : r_be;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= w_do_access;
      r_rdata <= (w_do_access && !w_acc_we) ? r_mem[w_acc_idx] : '0;
      case (r_state)
        S_IDLE: begin
          if (data_req) begin
            r_idx   <= w_idx_in;
            r_we    <= inst_we;
            r_wdata <= wdata;
            r_be    <= byte_enable;
            if (LATENCY > 1) begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is not reset; a reset edge suppresses the commit so an aborted store leaves no trace.
  always_ff @(posedge clk) begin
    if (rst && w_do_access && w_acc_we) begin
      for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
        if (w_acc_be[i]) r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

  assign data_valid = r_valid;
  assign rdata      = r_rdata;
  assign o_dbg_busy = (r_state == S_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven in turn,
// expected responses queued with their due cycle and checked by an independent monitor.
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{2, 1, 4};

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [NDUT];
  logic        req   [NDUT];
  logic [31:0] addr  [NDUT];
  logic        we    [NDUT];
  logic [31:0] wd    [NDUT];
  logic [3:0]  be    [NDUT];
  logic        valid [NDUT];
  logic [31:0] rd    [NDUT];
  logic        busy  [NDUT];

  exp_t exp_q [$];
  exp_t e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_addr(addr[0]), .inst_we(we[0]),
    .wdata(wd[0]), .byte_enable(be[0]), .data_valid(valid[0]), .rdata(rd[0]), .o_dbg_busy(busy[0])
  );
  dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_addr(addr[1]), .inst_we(we[1]),
    .wdata(wd[1]), .byte_enable(be[1]), .data_valid(valid[1]), .rdata(rd[1]), .o_dbg_busy(busy[1])
  );
  dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH(1024), .LATENCY(4)) u_dut2 (
    .clk(clk), .rst(rst[2]), .data_req(req[2]), .data_addr(addr[2]), .inst_we(we[2]),
    .wdata(wd[2]), .byte_enable(be[2]), .data_valid(valid[2]), .rdata(rd[2]), .o_dbg_busy(busy[2])
  );

  // Called just after a falling edge (cycle k); returns after the falling edge of cycle k+LATENCY
  // with data_req still high so a following call is a back-to-back request.
  task automatic do_req(input int d, input logic we_i, input logic [31:0] a, input logic [31:0] wd_i,
                        input logic [3:0] be_i, input logic [31:0] exp_d, input bit scramble);
    exp_t x;
    req[d] = 1'b1; we[d] = we_i; addr[d] = a; wd[d] = wd_i; be[d] = be_i;
    x.dut = d; x.data = exp_d; x.cyc = cyc + LAT[d];
    exp_q.push_back(x);
    for (int i = 0; i < LAT[d]; i++) begin
      @(negedge clk);
      if (scramble && i < LAT[d] - 1) begin
        addr[d] = $urandom; wd[d] = $urandom; we[d] = 1'($urandom_range(0, 1));
        be[d] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every valid pops one expectation; rdata must be zero whenever valid is low.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      n_tests++;
      if (valid[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid dut%0d cyc %0d: got rdata %h, required no response", k, cyc, rd[k]);
        end else begin
          e = exp_q.pop_front();
          if (e.dut != k || e.cyc != cyc || rd[k] !== e.data) begin
            n_fail++;
            $display("FAIL response: got dut%0d cyc %0d rdata %h, required dut%0d cyc %0d rdata %h",
                     k, cyc, rd[k], e.dut, e.cyc, e.data);
          end
        end
      end else if (valid[k] !== 1'b0 || rd[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_outputs dut%0d cyc %0d: got valid %b rdata %h, required valid 0 rdata 0",
                 k, cyc, valid[k], rd[k]);
      end
    end
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_valid dut%0d: got no response by cyc %0d, required at cyc %0d data %h",
               e.dut, cyc, e.cyc, e.data);
    end
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b0; req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; wd[k] = '0; be[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[1] = 1'b1; rst[2] = 1'b1;

    // LATENCY=2: request held during reset must be ignored
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wd[0] = 32'h1234_5678; be[0] = 4'hF;
    repeat (3) @(negedge clk);

    // Reset release and request in the same cycle, then store/load
    rst[0] = 1'b1;
    do_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    idle(0, 2);

    // Byte lanes and empty byte enable
    do_req(0, 1'b1, 32'h80, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b1, 32'h80, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h80, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);
    do_req(0, 1'b1, 32'h80, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h80, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    idle(0, 1);

    // Address wrap, low-bit and upper-bit aliasing
    do_req(0, 1'b1, 32'h1000, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h0000, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0);
    do_req(0, 1'b0, 32'h0003, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0);
    do_req(0, 1'b0, 32'hFFFF_F040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    idle(0, 3);

    // LATENCY=1 and LATENCY=4 back-to-back sweeps
    for (int d = 1; d < NDUT; d++) begin
      do_req(d, 1'b1, 32'h100, 32'hA1A2_A3A4, 4'hF, 32'h0, 1'b0);
      do_req(d, 1'b1, 32'h104, 32'hB1B2_B3B4, 4'hF, 32'h0, 1'b0);
      do_req(d, 1'b1, 32'h108, 32'hC1C2_C3C4, 4'hF, 32'h0, 1'b0);
      idle(d, 2);
      do_req(d, 1'b0, 32'h100, 32'h0, 4'h0, 32'hA1A2_A3A4, 1'b1);
      do_req(d, 1'b0, 32'h104, 32'h0, 4'h0, 32'hB1B2_B3B4, 1'b1);
      do_req(d, 1'b0, 32'h108, 32'h0, 4'h0, 32'hC1C2_C3C4, 1'b1);
      idle(d, 3);
    end

    // LATENCY=4: reset in the middle of a store aborts it
    do_req(2, 1'b1, 32'h20, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    idle(2, 2);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wd[2] = 32'hCAFE_F00D; be[2] = 4'hF;
    repeat (2) @(negedge clk);
    rst[2] = 1'b0; req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    repeat (6) @(negedge clk);
    do_req(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
    idle(2, 8);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
